// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the core-to-bus memory bridge.
package mem_bridge_pkg;

    localparam int unsigned MEM_BRIDGE_ADDR_W  = 32;
    localparam int unsigned MEM_BRIDGE_DATA_W  = 32;
    localparam int unsigned MEM_BRIDGE_TIMEOUT = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RSP   = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } mem_bridge_state_t;

    // Counter width able to hold values 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// Response timeout counter: cleared by load, counts while en, flags the last allowed cycle.
// Only instantiated when MEM_BRIDGE_TIMEOUT_EN is defined.
module mem_bridge_timer
    import mem_bridge_pkg::*;
#(
    parameter int unsigned CYCLES = MEM_BRIDGE_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = cnt_width(CYCLES);

    logic [CNT_W-1:0] count;

    // Expire on the CYCLES-th enabled cycle after load
    assign expire_c = en && (count == CNT_W'(CYCLES - 1));

    // Count enabled cycles, saturating at the expiry point
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en && !expire_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_bridge.sv
// Bridge from the RV32I core's level-held memory port to a valid/ready request/response bus.
// One transaction outstanding; each held core request is issued exactly once.
// Optional response timeout with late-response sinking: define MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned          ADDR_W         = MEM_BRIDGE_ADDR_W,
    parameter int unsigned          DATA_W         = MEM_BRIDGE_DATA_W,
    parameter int unsigned          TIMEOUT_CYCLES = MEM_BRIDGE_TIMEOUT,
    parameter logic [DATA_W-1:0]    ERR_RDATA      = DATA_W'(32'hDEADBEEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_resp,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_we,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [DATA_W-1:0]   bus_req_wdata,
    output logic [DATA_W/8-1:0] bus_req_be,
    input  logic                bus_rsp_valid,
    output logic                bus_rsp_ready,
    input  logic [DATA_W-1:0]   bus_rsp_rdata,
    input  logic                bus_rsp_err,
    output logic                bus_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    mem_bridge_state_t state;

    logic core_req_c;
    logic rsp_fire_c;
    logic drop_pending;
    logic timeout_c;

    assign core_req_c = mem_read | mem_write;
    assign rsp_fire_c = bus_rsp_valid & bus_rsp_ready;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    mem_bridge_timer #(
        .CYCLES   (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == REQ),
        .en       (state == RSP),
        .expire_c (timeout_c)
    );

    // A timed-out transaction leaves one late response to be absorbed outside RSP
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pending <= 1'b0;
        end else if (state == RSP && !bus_rsp_valid && timeout_c) begin
            drop_pending <= 1'b1;
        end else if (state != RSP && rsp_fire_c) begin
            drop_pending <= 1'b0;
        end
    end
`else
    assign timeout_c    = 1'b0;
    assign drop_pending = 1'b0;
`endif

    // Transaction FSM with registered bus and core-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem_rdata     <= '0;
            mem_resp      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_be    <= '0;
            bus_rsp_ready <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req_c && !drop_pending) begin
                        bus_req_valid <= 1'b1;
                        bus_req_we    <= mem_write;
                        bus_req_addr  <= mem_addr;
                        bus_req_wdata <= mem_wdata;
                        bus_req_be    <= mem_write ? mem_be : '1;
                        if (mem_read && mem_write) begin
                            bus_err <= 1'b1;
                        end
                        state <= REQ;
                    end else if (rsp_fire_c) begin
                        bus_rsp_ready <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        bus_rsp_ready <= 1'b1;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (bus_rsp_valid) begin
                        bus_rsp_ready <= 1'b0;
                        if (!bus_req_we) begin
                            mem_rdata <= bus_rsp_err ? ERR_RDATA : bus_rsp_rdata;
                        end
                        if (bus_rsp_err) begin
                            bus_err <= 1'b1;
                        end
                        mem_resp <= 1'b1;
                        state    <= RESP;
                    end else if (timeout_c) begin
                        bus_rsp_ready <= 1'b0;
                        if (!bus_req_we) begin
                            mem_rdata <= ERR_RDATA;
                        end
                        bus_err  <= 1'b1;
                        mem_resp <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    bus_rsp_ready <= drop_pending;
                    state         <= DRAIN;
                end
                DRAIN: begin
                    if (rsp_fire_c) begin
                        bus_rsp_ready <= 1'b0;
                    end
                    if (!core_req_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed plus randomized checks of mem_bridge against a transaction-level model.
module tb_mem_bridge;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [BW-1:0] mem_be = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_resp;
    logic          bus_req_valid;
    logic          bus_req_ready = 1'b0;
    logic          bus_req_we;
    logic [AW-1:0] bus_req_addr;
    logic [DW-1:0] bus_req_wdata;
    logic [BW-1:0] bus_req_be;
    logic          bus_rsp_valid = 1'b0;
    logic          bus_rsp_ready;
    logic [DW-1:0] bus_rsp_rdata = '0;
    logic          bus_rsp_err = 1'b0;
    logic          bus_err;

    mem_bridge #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_we    (bus_req_we),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_be    (bus_req_be),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_ready (bus_rsp_ready),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int acc_cnt = 0;

    // Reference model state
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;
    int          exp_acc   = 0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) acc_cnt <= 0;
        else if (bus_req_valid && bus_req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {27'b0, mem_resp, bus_req_valid, bus_req_we, bus_rsp_ready, bus_err}, 32'h0);
        chk({tag, "_addr"}, bus_req_addr, 32'h0);
        chk({tag, "_wdata"}, bus_req_wdata, 32'h0);
        chk({tag, "_be"}, {28'b0, bus_req_be}, 32'h0);
        chk({tag, "_rdata"}, mem_rdata, 32'h0);
    endtask

    // One complete core transaction with a behavioural bus responder
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int rdly, input int sdly,
                       input logic [31:0] rdat, input bit err, input int hold, input bit chk_lat);
        int c0;
        int n;
        logic [3:0] eb;
        eb = wr ? be : 4'hF;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        mem_be    = be;
        c0 = cycle;
        n = 0;
        while (bus_req_valid !== 1'b1 && n < 32) begin
            tick();
            n++;
        end
        chk("req_valid", {31'b0, bus_req_valid}, 32'h1);
        // core payload changes after issue must not leak onto the bus
        mem_addr  = $urandom & 32'hFFFF_FFFC;
        mem_wdata = $urandom;
        mem_be    = 4'($urandom);
        for (int i = 0; i <= rdly; i++) begin
            chk("req_hold_valid", {31'b0, bus_req_valid}, 32'h1);
            chk("req_addr", bus_req_addr, a);
            chk("req_wdata", bus_req_wdata, wd);
            chk("req_we_be", {27'b0, bus_req_we, bus_req_be}, {27'b0, wr, eb});
            if (i == rdly) bus_req_ready = 1'b1;
            tick();
            bus_req_ready = 1'b0;
        end
        exp_acc++;
        chk("req_valid_drop", {31'b0, bus_req_valid}, 32'h0);
        chk("rsp_ready", {31'b0, bus_rsp_ready}, 32'h1);
        for (int i = 0; i < sdly; i++) begin
            chk("rsp_wait_resp", {31'b0, mem_resp}, 32'h0);
            tick();
        end
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = rdat;
        bus_rsp_err   = err;
        tick();
        bus_rsp_valid = 1'b0;
        bus_rsp_err   = 1'b0;
        bus_rsp_rdata = $urandom;
        if (rd && !wr) exp_rdata = err ? ERR : rdat;
        if (err || (rd && wr)) exp_err = 1'b1;
        chk("mem_resp", {31'b0, mem_resp}, 32'h1);
        chk("mem_rdata", mem_rdata, exp_rdata);
        chk("bus_err", {31'b0, bus_err}, {31'b0, exp_err});
        if (chk_lat) chk("latency", 32'(cycle - c0), 32'd3);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("no_reissue", {31'b0, bus_req_valid}, 32'h0);
            chk("resp_single", {31'b0, mem_resp}, 32'h0);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        chk("resp_single_end", {31'b0, mem_resp}, 32'h0);
        tick();
        chk("accepted", 32'(acc_cnt), 32'(exp_acc));
    endtask

    initial begin
        int r;
        int k;
        bit rd;
        bit wr;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Zero-wait read, latency 3
        txn(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'h12345678, 0, 0, 1);

        // Write with ready held low 5 cycles
        txn(0, 1, 32'h0000_1004, 32'hCAFE_F00D, 4'b0011, 5, 1, 32'h0, 0, 0, 0);

        // Read held 4 cycles after completion
        txn(1, 0, 32'h0000_2000, 32'h0, 4'h0, 0, 2, 32'h0BAD_C0DE, 0, 4, 0);

        // Randomized good transactions
        for (int t = 0; t < 10; t++) begin
            r  = $urandom_range(0, 1);
            rd = (r == 0);
            wr = (r == 1);
            txn(rd, wr, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0,
                $urandom_range(0, 2), 0);
        end

        // Error read, then sticky flag through a good transaction
        txn(1, 0, 32'h0000_3000, 32'h0, 4'h0, 1, 0, 32'h5555_AAAA, 1, 0, 0);
        txn(1, 0, 32'h0000_3004, 32'h0, 4'h0, 0, 0, 32'h1111_2222, 0, 0, 0);

        // Randomized including errors and simultaneous read+write
        for (int t = 0; t < 10; t++) begin
            r  = $urandom_range(0, 7);
            rd = (r < 4) || (r == 7);
            wr = (r >= 4);
            txn(rd, wr, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 1), 0);
        end

        // Reset while a request is pending
        mem_read = 1'b1;
        mem_addr = 32'h0000_4000;
        k = 0;
        while (bus_req_valid !== 1'b1 && k < 32) begin
            tick();
            k++;
        end
        chk("rst_mid_req_valid", {31'b0, bus_req_valid}, 32'h1);
        rst = 1'b1;
        mem_read = 1'b0;
        tick();
        rst = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        exp_acc   = 0;
        chk_idle_outputs("rst_mid");
        tick();
        txn(1, 0, 32'h0000_4000, 32'h0, 4'h0, 0, 0, 32'h7777_8888, 0, 0, 1);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // Timeout, then a late response is sunk and the next read returns fresh data
        mem_read = 1'b1;
        mem_addr = 32'h0000_5000;
        k = 0;
        while (bus_req_valid !== 1'b1 && k < 32) begin
            tick();
            k++;
        end
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        exp_acc++;
        k = 0;
        while (mem_resp !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        exp_rdata = ERR;
        exp_err   = 1'b1;
        chk("timeout_cycles", 32'(k), 32'(TO));
        chk("timeout_rdata", mem_rdata, exp_rdata);
        chk("timeout_err", {31'b0, bus_err}, 32'h1);
        mem_read = 1'b0;
        tick();
        chk("drop_ready", {31'b0, bus_rsp_ready}, 32'h1);
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hAAAA5555;
        tick();
        bus_rsp_valid = 1'b0;
        chk("drop_ready_clr", {31'b0, bus_rsp_ready}, 32'h0);
        chk("drop_no_resp", {31'b0, mem_resp}, 32'h0);
        chk("drop_rdata", mem_rdata, exp_rdata);
        tick();
        txn(1, 0, 32'h0000_5004, 32'h0, 4'h0, 0, 0, 32'h600D_F00D, 0, 0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
